// File: rtl/mapa_pkg.sv
// Shared definitions for the snake map-cell protocol: cell codes, directions,
// coordinate width and the map controller state type.
package mapa_pkg;

  localparam int COORD_W = 10;

  localparam logic [3:0] CELL_VAZIO     = 4'b0000;
  localparam logic [3:0] CELL_OBSTACULO = 4'b0001;
  localparam logic [3:0] CELL_FRUTA     = 4'b0010;
  localparam logic [3:0] CELL_COBRA_MSB = 4'b1000;

  localparam logic [1:0] DIR_CIMA  = 2'd0;
  localparam logic [1:0] DIR_BAIXO = 2'd1;
  localparam logic [1:0] DIR_ESQ   = 2'd2;
  localparam logic [1:0] DIR_DIR   = 2'd3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } mapa_state_e;

  function automatic logic [3:0] cobra_cell(input logic [1:0] dir);
    return CELL_COBRA_MSB | {2'b00, dir};
  endfunction

endpackage

// File: rtl/mapa_ram.sv
// Simple dual-port synchronous map RAM, DEPTH x 4: port A write plus
// registered read, port B registered read only.
module mapa_ram #(
  parameter int DEPTH = 1200,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [3:0]    a_wdata,
  input  logic          a_re,
  input  logic [AW-1:0] a_raddr,
  output logic [3:0]    a_rdata,
  input  logic [AW-1:0] b_raddr,
  output logic [3:0]    b_rdata
);

  logic [3:0] mem_q [DEPTH];
  logic [3:0] a_rdata_q;
  logic [3:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_waddr] <= a_wdata;
    if (a_re) a_rdata_q <= mem_q[a_raddr];
    b_rdata_q <= mem_q[b_raddr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/mapa_mem_ctrl.sv
// Game map RAM owner: post-reset clear sweep, update/spawner write arbitration
// and VGA read port. Define MAPA_BORDER_EN to sweep a solid obstacle border.
module mapa_mem_ctrl
  import mapa_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               update_renable,
  input  logic [COORD_W-1:0] update_rx,
  input  logic [COORD_W-1:0] update_ry,
  output logic [3:0]         update_rdata,
  input  logic               update_wenable,
  input  logic [COORD_W-1:0] update_wx,
  input  logic [COORD_W-1:0] update_wy,
  input  logic [3:0]         update_wdata,
  input  logic               fruta_req,
  input  logic [COORD_W-1:0] fruta_wx,
  input  logic [COORD_W-1:0] fruta_wy,
  output logic               fruta_busy,
  input  logic               obstaculo_req,
  input  logic [COORD_W-1:0] obstaculo_wx,
  input  logic [COORD_W-1:0] obstaculo_wy,
  output logic               obstaculo_busy,
  input  logic [COORD_W-1:0] vga_x,
  input  logic [COORD_W-1:0] vga_y,
  output logic [3:0]         vga_rdata,
  output logic               mapa_pronto
);

  localparam int DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] addr_t;

  function automatic logic in_range(input coord_t x, input coord_t y);
    return (int'(x) < MAPA_WIDTH) && (int'(y) < MAPA_HEIGHT);
  endfunction

  function automatic addr_t to_addr(input coord_t x, input coord_t y);
    int a;
    a = int'(y) * MAPA_WIDTH + int'(x);
    return addr_t'(a);
  endfunction

  mapa_state_e state_q, state_d;
  addr_t       clr_cnt_q, clr_cnt_d;
  coord_t      clr_x_q, clr_x_d, clr_y_q, clr_y_d;
  logic        f_pend_q, f_pend_d, o_pend_q, o_pend_d;
  coord_t      f_x_q, f_x_d, f_y_q, f_y_d, o_x_q, o_x_d, o_y_q, o_y_d;
  logic        rd_byp_q, rd_byp_d, vga_byp_q, vga_byp_d;
  logic [3:0]  rd_byp_val_q, rd_byp_val_d;
  logic        pronto_q, pronto_d;

  logic        we, f_drain, o_drain, upd_wr_ok, upd_rd_ok, vga_ok;
  addr_t       wa, ra, vra;
  logic [3:0]  wd, ram_a_rdata, ram_b_rdata;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
    f_pend_d     = f_pend_q;
    f_x_d        = f_x_q;
    f_y_d        = f_y_q;
    o_pend_d     = o_pend_q;
    o_x_d        = o_x_q;
    o_y_d        = o_y_q;
    rd_byp_d     = rd_byp_q;
    rd_byp_val_d = rd_byp_val_q;
    vga_byp_d    = vga_byp_q;
    pronto_d     = pronto_q;
    we           = 1'b0;
    wa           = '0;
    wd           = CELL_VAZIO;
    f_drain      = 1'b0;
    o_drain      = 1'b0;
    upd_wr_ok    = update_wenable && in_range(update_wx, update_wy);
    upd_rd_ok    = in_range(update_rx, update_ry);
    vga_ok       = in_range(vga_x, vga_y);
    ra           = upd_rd_ok ? to_addr(update_rx, update_ry) : '0;
    vra          = vga_ok ? to_addr(vga_x, vga_y) : '0;

    case (state_q)
      ST_CLEAR: begin
        we = 1'b1;
        wa = clr_cnt_q;
`ifdef MAPA_BORDER_EN
        if (clr_x_q == '0 || int'(clr_x_q) == MAPA_WIDTH - 1 ||
            clr_y_q == '0 || int'(clr_y_q) == MAPA_HEIGHT - 1)
          wd = CELL_OBSTACULO;
`endif
        if (int'(clr_cnt_q) == DEPTH - 1) begin
          state_d  = ST_RUN;
          pronto_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (int'(clr_x_q) == MAPA_WIDTH - 1) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + 1'b1;
          end else begin
            clr_x_d = clr_x_q + 1'b1;
          end
        end
        if (update_renable) begin
          rd_byp_d     = 1'b1;
          rd_byp_val_d = CELL_VAZIO;
        end
        vga_byp_d = 1'b1;
      end
      default: begin
        // Out-of-range slots still win arbitration so they drain without writing.
        if (upd_wr_ok) begin
          we = 1'b1;
          wa = to_addr(update_wx, update_wy);
          wd = update_wdata;
        end else if (o_pend_q) begin
          o_drain = 1'b1;
          we      = in_range(o_x_q, o_y_q);
          wa      = to_addr(o_x_q, o_y_q);
          wd      = CELL_OBSTACULO;
        end else if (f_pend_q) begin
          f_drain = 1'b1;
          we      = in_range(f_x_q, f_y_q);
          wa      = to_addr(f_x_q, f_y_q);
          wd      = CELL_FRUTA;
        end
        if (update_renable) begin
          rd_byp_d     = 1'b1;
          rd_byp_val_d = CELL_VAZIO;
          if (!upd_rd_ok)
            rd_byp_val_d = CELL_OBSTACULO;
          else if (upd_wr_ok && update_rx == update_wx && update_ry == update_wy)
            rd_byp_val_d = update_wdata;
          else
            rd_byp_d = 1'b0;
        end
        vga_byp_d = !vga_ok;
      end
    endcase

    if (f_drain || !f_pend_q) begin
      f_pend_d = fruta_req;
      if (fruta_req) begin
        f_x_d = fruta_wx;
        f_y_d = fruta_wy;
      end
    end
    if (o_drain || !o_pend_q) begin
      o_pend_d = obstaculo_req;
      if (obstaculo_req) begin
        o_x_d = obstaculo_wx;
        o_y_d = obstaculo_wy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      f_pend_q     <= 1'b0;
      f_x_q        <= '0;
      f_y_q        <= '0;
      o_pend_q     <= 1'b0;
      o_x_q        <= '0;
      o_y_q        <= '0;
      rd_byp_q     <= 1'b1;
      rd_byp_val_q <= CELL_VAZIO;
      vga_byp_q    <= 1'b1;
      pronto_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
      f_pend_q     <= f_pend_d;
      f_x_q        <= f_x_d;
      f_y_q        <= f_y_d;
      o_pend_q     <= o_pend_d;
      o_x_q        <= o_x_d;
      o_y_q        <= o_y_d;
      rd_byp_q     <= rd_byp_d;
      rd_byp_val_q <= rd_byp_val_d;
      vga_byp_q    <= vga_byp_d;
      pronto_q     <= pronto_d;
    end
  end

  mapa_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .a_we    (we && reset_n),
    .a_waddr (wa),
    .a_wdata (wd),
    .a_re    (update_renable),
    .a_raddr (ra),
    .a_rdata (ram_a_rdata),
    .b_raddr (vra),
    .b_rdata (ram_b_rdata)
  );

  assign update_rdata   = rd_byp_q ? rd_byp_val_q : ram_a_rdata;
  assign vga_rdata      = vga_byp_q ? CELL_VAZIO : ram_b_rdata;
  assign fruta_busy     = f_pend_q;
  assign obstaculo_busy = o_pend_q;
  assign mapa_pronto    = pronto_q;

endmodule

// File: tb/tb_mapa_mem_ctrl.sv
// Scoreboard bench for mapa_mem_ctrl: a behavioural map model predicts every
// output, a negedge monitor compares. Honours MAPA_BORDER_EN like the RTL.
module tb_mapa_mem_ctrl;

  localparam int W     = 40;
  localparam int H     = 30;
  localparam int DEPTH = W * H;

  localparam int K_RD = 0, K_VGA = 1, K_PRONTO = 2, K_FB = 3, K_OB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       update_renable, update_wenable, fruta_req, obstaculo_req;
  logic [9:0] update_rx, update_ry, update_wx, update_wy;
  logic [9:0] fruta_wx, fruta_wy, obstaculo_wx, obstaculo_wy, vga_x, vga_y;
  logic [3:0] update_wdata, update_rdata, vga_rdata;
  logic       fruta_busy, obstaculo_busy, mapa_pronto;

  mapa_mem_ctrl #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
    .update_rdata(update_rdata),
    .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
    .update_wdata(update_wdata),
    .fruta_req(fruta_req), .fruta_wx(fruta_wx), .fruta_wy(fruta_wy), .fruta_busy(fruta_busy),
    .obstaculo_req(obstaculo_req), .obstaculo_wx(obstaculo_wx), .obstaculo_wy(obstaculo_wy),
    .obstaculo_busy(obstaculo_busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rdata(vga_rdata), .mapa_pronto(mapa_pronto)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int exp;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model: the map as a plain array plus the two spawner requests.
  int mem [DEPTH];
  bit running;
  int sweep_left;
  bit fp, op;
  int fx, fy, ox, oy;

  function automatic bit inb(input int x, input int y);
    return x < W && y < H;
  endfunction

  function automatic int cleared_cell(input int x, input int y);
`ifdef MAPA_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 1;
`endif
    return 0;
  endfunction

  function automatic void push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) begin
    bit wr, f_dr, o_dr;
    int waddr, wval, rx, ry, wx, wy, vx, vy;
    rx = int'(update_rx); ry = int'(update_ry);
    wx = int'(update_wx); wy = int'(update_wy);
    vx = int'(vga_x);     vy = int'(vga_y);
    wr = 0; f_dr = 0; o_dr = 0; waddr = -1; wval = 0;
    if (!reset_n) begin
      running = 0; sweep_left = DEPTH; fp = 0; op = 0;
      push(K_RD, 0); push(K_VGA, 0);
    end else begin
      if (!running) begin
        if (update_renable) push(K_RD, 0);
        push(K_VGA, 0);
        sweep_left--;
        if (sweep_left == 0) begin
          running = 1;
          for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mem[y * W + x] = cleared_cell(x, y);
        end
      end else begin
        if (update_wenable && inb(wx, wy)) begin
          wr = 1; waddr = wy * W + wx; wval = int'(update_wdata);
        end else if (op) begin
          o_dr = 1;
          if (inb(ox, oy)) begin wr = 1; waddr = oy * W + ox; wval = 1; end
        end else if (fp) begin
          f_dr = 1;
          if (inb(fx, fy)) begin wr = 1; waddr = fy * W + fx; wval = 2; end
        end
        if (update_renable) begin
          if (!inb(rx, ry)) push(K_RD, 1);
          else if (update_wenable && rx == wx && ry == wy) push(K_RD, int'(update_wdata));
          else push(K_RD, mem[ry * W + rx]);
        end
        if (!inb(vx, vy)) push(K_VGA, 0);
        else if (!(wr && waddr == vy * W + vx)) push(K_VGA, mem[vy * W + vx]);
        if (wr) mem[waddr] = wval;
      end
      if (fruta_req && (!fp || f_dr)) begin
        fp = 1; fx = int'(fruta_wx); fy = int'(fruta_wy);
      end else if (f_dr) fp = 0;
      if (obstaculo_req && (!op || o_dr)) begin
        op = 1; ox = int'(obstaculo_wx); oy = int'(obstaculo_wy);
      end else if (o_dr) op = 0;
    end
    push(K_PRONTO, int'(running));
    push(K_FB, int'(fp));
    push(K_OB, int'(op));
  end

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] act;
    string nm;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RD:     begin act = update_rdata;            nm = "update_rdata";   end
        K_VGA:    begin act = vga_rdata;               nm = "vga_rdata";      end
        K_PRONTO: begin act = {3'b000, mapa_pronto};   nm = "mapa_pronto";    end
        K_FB:     begin act = {3'b000, fruta_busy};    nm = "fruta_busy";     end
        default:  begin act = {3'b000, obstaculo_busy}; nm = "obstaculo_busy"; end
      endcase
      checks++;
      if (act === 4'(e.exp)) passes++;
      else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, 4'(e.exp));
    end
  end

  task automatic step();
    @(negedge clk);
    update_renable = 0; update_wenable = 0; fruta_req = 0; obstaculo_req = 0;
    update_rx = 0; update_ry = 0; update_wx = 0; update_wy = 0; update_wdata = 0;
    fruta_wx = 0; fruta_wy = 0; obstaculo_wx = 0; obstaculo_wy = 0;
    vga_x = 10'($urandom_range(W - 1)); vga_y = 10'($urandom_range(H - 1));
  endtask

  task automatic check_reset();
    logic [11:0] got;
    got = {update_rdata, vga_rdata, fruta_busy, obstaculo_busy, mapa_pronto, 1'b0};
    checks++;
    if (got === '0) passes++;
    else $display("FAIL reset state at %0t: rdata=%b vga=%b fb=%b ob=%b pronto=%b",
                  $time, update_rdata, vga_rdata, fruta_busy, obstaculo_busy, mapa_pronto);
  endtask

  task automatic wait_pronto(input int max_cycles);
    int n;
    n = 0;
    while (n < max_cycles && mapa_pronto !== 1'b1) begin
      step();
      n++;
    end
    checks++;
    if (mapa_pronto === 1'b1) passes++;
    else $display("FAIL mapa_pronto wait expired after %0d cycles at %0t", n, $time);
  endtask

  function automatic logic [9:0] rc(input int lim);
    int r;
    r = int'($urandom % 16);
    if (r == 0) return 10'(lim);
    if (r == 1) return 10'($urandom % 1024);
    return 10'($urandom % lim);
  endfunction

  task automatic random_cycle(input bit allow_req);
    step();
    update_renable = 1'($urandom % 2);
    update_rx = rc(W); update_ry = rc(H);
    update_wenable = ($urandom % 3) == 0;
    update_wx = rc(W); update_wy = rc(H); update_wdata = 4'($urandom);
    if (($urandom % 4) == 0) begin update_rx = update_wx; update_ry = update_wy; end
    vga_x = rc(W); vga_y = rc(H);
    if (allow_req) begin
      fruta_req = ($urandom % 6) == 0;
      fruta_wx = rc(W); fruta_wy = rc(H);
      obstaculo_req = ($urandom % 6) == 0;
      obstaculo_wx = rc(W); obstaculo_wy = rc(H);
    end
  endtask

  task automatic rd(input int x, input int y);
    step();
    update_renable = 1; update_rx = 10'(x); update_ry = 10'(y);
  endtask

  task automatic wr_cell(input int x, input int y, input logic [3:0] v);
    step();
    update_wenable = 1; update_wx = 10'(x); update_wy = 10'(y); update_wdata = v;
  endtask

  initial begin
    reset_n = 0;
    step(); reset_n = 0; fruta_req = 1;
    step(); reset_n = 0;
    step(); reset_n = 0;
    step(); reset_n = 1;
    check_reset();
    for (int i = 0; i < DEPTH + 5; i++) begin
      random_cycle(0);
      if (i == 10) begin fruta_req = 1; fruta_wx = 7; fruta_wy = 8; end
      if (i == 20) begin obstaculo_req = 1; obstaculo_wx = 9; obstaculo_wy = 8; end
    end
    rd(0, 5); rd(5, 5); rd(7, 8); rd(9, 8);

    wr_cell(3, 4, 4'b1011);
    rd(3, 4);
    wr_cell(3, 4, 4'b1001); update_renable = 1; update_rx = 3; update_ry = 4;
    step();

    wr_cell(20, 20, 4'b1100);
    fruta_req = 1; fruta_wx = 10; fruta_wy = 10;
    obstaculo_req = 1; obstaculo_wx = 11; obstaculo_wy = 10;
    repeat (4) step();
    rd(10, 10); rd(11, 10); rd(20, 20);

    step(); fruta_req = 1; fruta_wx = 12; fruta_wy = 12;
    wr_cell(1, 1, 4'b1010); fruta_req = 1; fruta_wx = 13; fruta_wy = 12;
    repeat (3) step();
    rd(12, 12); rd(13, 12);

    rd(40, 0); vga_x = 40; vga_y = 0;
    wr_cell(0, 30, 4'b1111);
    rd(0, 29); rd(0, 30);
    step();

    for (int i = 0; i < 3000; i++) random_cycle(1);

    step(); reset_n = 0;
    step(); reset_n = 1;
    for (int i = 0; i < 500; i++) begin
      random_cycle(0);
      if (i == 480) begin fruta_req = 1; fruta_wx = 5; fruta_wy = 6; end
    end
    step(); reset_n = 0;
    step(); reset_n = 1;
    wait_pronto(DEPTH + 2);
    for (int i = 0; i < 10; i++) random_cycle(1);
    for (int i = 0; i < 500; i++) random_cycle(1);
    repeat (4) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
